// File: rtl/rocc_op_dispatch.sv
`default_nettype none
// ============================================================================
// Module : rocc_op_dispatch
// RoCC command front end: decodes funct7 to one of NUM_OPS units, drives the
// STB/BUSY handshake, writes the result back and optionally responds.
// Rev    : 1.0
// ============================================================================
module rocc_op_dispatch #(
  parameter int INST_WIDTH     = 32,
  parameter int DATA_WIDTH     = 64,
  parameter int OP_WIDTH       = 32,
  parameter int NUM_OPS        = 5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [INST_WIDTH-6:0]        cmd_inst,
  input  logic [DATA_WIDTH-1:0]        cmd_rs1,
  input  logic [DATA_WIDTH-1:0]        cmd_rs2,
  output logic [OP_WIDTH-1:0]          op_a,
  output logic [OP_WIDTH-1:0]          op_b,
  output logic [OP_WIDTH-1:0]          op_c,
  output logic [OP_WIDTH-1:0]          op_d,
  output logic [NUM_OPS-1:0]           op_in_stb,
  input  logic [NUM_OPS-1:0]           op_busy,
  input  logic [NUM_OPS-1:0]           op_out_stb,
  input  logic [NUM_OPS*OP_WIDTH-1:0]  op_result,
  output logic [NUM_OPS-1:0]           op_out_busy,
  output logic                         rf_we,
  output logic [4:0]                   rf_waddr,
  output logic [OP_WIDTH-1:0]          rf_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [4:0]                   resp_rd,
  output logic [DATA_WIDTH-1:0]        resp_data,
  output logic                         resp_err,
  output logic                         busy
);

  localparam int              SEL_W     = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1;
  localparam int              WD_W      = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [7:0]      NUM_OPS_W = 8'(NUM_OPS);
  localparam logic [WD_W-1:0] WD_LOAD   = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0] WD_ONE    = WD_W'(1);
  localparam bit              WD_EN     = (TIMEOUT_CYCLES != 0);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_ERR   = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  logic [SEL_W-1:0]    sel;
  logic [4:0]          rd;
  logic                xd;
  logic [OP_WIDTH-1:0] result;
  logic [WD_W-1:0]     wd;

  logic [6:0]          funct7;
  logic                dec_legal;
  logic [SEL_W-1:0]    dec_sel;
  logic [NUM_OPS-1:0]  dec_onehot;
  logic [NUM_OPS-1:0]  sel_onehot;
  logic [OP_WIDTH-1:0] sel_result;
  logic                accept;
  logic                issue_ack;
  logic                take;
  logic                expire;

  logic unused_inst;
  assign unused_inst = ^{cmd_inst[INST_WIDTH-13:10], cmd_inst[8:7], cmd_inst[1:0]};

  always_comb begin
    funct7     = cmd_inst[INST_WIDTH-6 -: 7];
    dec_legal  = (funct7 != 7'd0) && ({1'b0, funct7} <= NUM_OPS_W);
    dec_sel    = SEL_W'(funct7 - 7'd1);
    dec_onehot = NUM_OPS'(1) << dec_sel;
    sel_onehot = NUM_OPS'(1) << sel;
    sel_result = '0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (SEL_W'(i) == sel) begin
        sel_result = op_result[i*OP_WIDTH +: OP_WIDTH];
      end
    end
    accept    = (state == S_IDLE) && cmd_valid && cmd_ready;
    issue_ack = (state == S_ISSUE) && |(op_in_stb & op_busy & sel_onehot);
    take      = (state == S_WAIT) && |(op_out_stb & ~op_out_busy & sel_onehot);
    // wd holds the cycles left including the current one
    expire    = WD_EN && ((state == S_ISSUE) || (state == S_WAIT)) && (wd == WD_ONE);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept) state_next = dec_legal ? S_ISSUE : S_ERR;
      S_ISSUE: begin
        if (expire)         state_next = S_ERR;
        else if (issue_ack) state_next = S_WAIT;
      end
      S_WAIT: begin
        // a result arriving on the expiry cycle still completes normally
        if (take)        state_next = S_WB;
        else if (expire) state_next = S_ERR;
      end
      S_WB:    state_next = xd ? S_RESP : S_IDLE;
      S_ERR:   state_next = xd ? S_RESP : S_IDLE;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cmd_ready   <= 1'b1;
      busy        <= 1'b0;
      sel         <= '0;
      rd          <= '0;
      xd          <= 1'b0;
      result      <= '0;
      wd          <= '0;
      op_a        <= '0;
      op_b        <= '0;
      op_c        <= '0;
      op_d        <= '0;
      op_in_stb   <= '0;
      op_out_busy <= '1;
      rf_we       <= 1'b0;
      rf_waddr    <= '0;
      rf_wdata    <= '0;
      resp_valid  <= 1'b0;
      resp_rd     <= '0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
    end else begin
      rf_we     <= 1'b0;
      busy      <= (state_next != S_IDLE);
      cmd_ready <= (state_next == S_IDLE);
      if (WD_EN && ((state == S_ISSUE) || (state == S_WAIT))) begin
        wd <= wd - WD_ONE;
      end
      case (state)
        S_IDLE: begin
          if (accept) begin
            sel  <= dec_sel;
            rd   <= cmd_inst[6:2];
            xd   <= cmd_inst[9];
            op_a <= cmd_rs1[2*OP_WIDTH-1:OP_WIDTH];
            op_b <= cmd_rs1[OP_WIDTH-1:0];
            op_c <= cmd_rs2[2*OP_WIDTH-1:OP_WIDTH];
            op_d <= cmd_rs2[OP_WIDTH-1:0];
            wd   <= WD_LOAD;
            if (dec_legal) op_in_stb <= dec_onehot;
          end
        end
        S_ISSUE: begin
          if (expire) begin
            op_in_stb <= '0;
          end else if (issue_ack) begin
            op_in_stb   <= '0;
            op_out_busy <= ~sel_onehot;
          end
        end
        S_WAIT: begin
          if (take) begin
            result      <= sel_result;
            op_out_busy <= '1;
            rf_we       <= 1'b1;
            rf_waddr    <= rd;
            rf_wdata    <= sel_result;
          end else if (expire) begin
            op_out_busy <= '1;
          end
        end
        S_WB: begin
          if (xd) begin
            resp_valid <= 1'b1;
            resp_rd    <= rd;
            resp_data  <= {{(DATA_WIDTH-OP_WIDTH){1'b0}}, result};
            resp_err   <= 1'b0;
          end
        end
        S_ERR: begin
          result <= '0;
          if (xd) begin
            resp_valid <= 1'b1;
            resp_rd    <= rd;
            resp_data  <= '0;
            resp_err   <= 1'b1;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
          end
        end
        default: begin
          op_in_stb   <= '0;
          op_out_busy <= '1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rocc_op_dispatch.sv
`default_nettype none
// ============================================================================
// Module : tb_rocc_op_dispatch
// Scoreboard bench for rocc_op_dispatch with reactive unit models.
// Rev    : 1.0
// ============================================================================
module tb_rocc_op_dispatch;

  localparam int INST_WIDTH     = 32;
  localparam int DATA_WIDTH     = 64;
  localparam int OP_WIDTH       = 32;
  localparam int NUM_OPS        = 5;
  localparam int TIMEOUT_CYCLES = 8;
  localparam int NEVER          = 1 << 20;

  logic                        clk = 1'b0;
  logic                        rst = 1'b0;
  logic                        cmd_valid;
  logic                        cmd_ready;
  logic [INST_WIDTH-6:0]       cmd_inst;
  logic [DATA_WIDTH-1:0]       cmd_rs1;
  logic [DATA_WIDTH-1:0]       cmd_rs2;
  logic [OP_WIDTH-1:0]         op_a, op_b, op_c, op_d;
  logic [NUM_OPS-1:0]          op_in_stb;
  logic [NUM_OPS-1:0]          op_busy;
  logic [NUM_OPS-1:0]          op_out_stb;
  logic [NUM_OPS*OP_WIDTH-1:0] op_result;
  logic [NUM_OPS-1:0]          op_out_busy;
  logic                        rf_we;
  logic [4:0]                  rf_waddr;
  logic [OP_WIDTH-1:0]         rf_wdata;
  logic                        resp_valid;
  logic                        resp_ready;
  logic [4:0]                  resp_rd;
  logic [DATA_WIDTH-1:0]       resp_data;
  logic                        resp_err;
  logic                        busy;

  rocc_op_dispatch #(
    .INST_WIDTH(INST_WIDTH), .DATA_WIDTH(DATA_WIDTH), .OP_WIDTH(OP_WIDTH),
    .NUM_OPS(NUM_OPS), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_inst(cmd_inst),
    .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2),
    .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
    .op_in_stb(op_in_stb), .op_busy(op_busy), .op_out_stb(op_out_stb),
    .op_result(op_result), .op_out_busy(op_out_busy),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd(resp_rd),
    .resp_data(resp_data), .resp_err(resp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NUM_OPS-1:0] onehot;
    logic [31:0]        a, b, c, d;
    int                 cycles;
  } iss_t;
  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } rf_t;
  typedef struct {
    logic [4:0]  rd;
    logic [63:0] data;
    logic        err;
  } resp_t;

  iss_t  iss_q[$];
  rf_t   rf_q[$];
  resp_t resp_q[$];

  int errors = 0;
  int checks = 0;

  // unit plan for the command in flight
  int          pu = 0, pk = 0, pm = 0, icnt = 0, wcnt = 0;
  logic [31:0] pres = '0;
  int          hold_low = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_values(input string tag);
    logic [NUM_OPS-1:0] ones;
    ones = '1;
    chk({tag, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_op_in_stb"}, 64'(op_in_stb), 64'd0);
    chk({tag, "_op_out_busy"}, 64'(op_out_busy), 64'(ones));
    chk({tag, "_rf_we"}, 64'(rf_we), 64'd0);
    chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
    chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
    chk({tag, "_op_ab"}, {op_a, op_b}, 64'd0);
    chk({tag, "_resp_data"}, resp_data, 64'd0);
  endtask

  // Waits (bounded) for the DUT to return to idle, pulsing junk commands meanwhile.
  task automatic wait_idle();
    int n;
    n = 0;
    while (!cmd_ready && n < 300) begin
      cmd_valid = 1'($urandom);
      cmd_inst  = (INST_WIDTH-5)'($urandom);
      @(posedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    if (!cmd_ready) chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
  endtask

  // Reference model: a legal command succeeds iff the ack comes before the
  // watchdog's last cycle and ack+result delays fit within TIMEOUT_CYCLES.
  task automatic send(input logic [6:0] f7, input logic [63:0] rs1, input logic [63:0] rs2,
                      input logic xd, input logic [4:0] rd, input int k, input int m,
                      input logic [31:0] res, input bit expect_out);
    bit    legal, ok;
    int    ke, me;
    iss_t  it;
    rf_t   rw;
    resp_t rp;
    wait_idle();
    legal = (f7 >= 7'd1) && (int'(f7) <= NUM_OPS);
    ok    = 1'b0;
    if (legal) begin
      ke = (k == 0) ? NEVER : k;
      me = (m == 0) ? NEVER : m;
      it.onehot = NUM_OPS'(1) << (int'(f7) - 1);
      it.a = rs1[63:32]; it.b = rs1[31:0]; it.c = rs2[63:32]; it.d = rs2[31:0];
      it.cycles = (ke < TIMEOUT_CYCLES) ? ke : TIMEOUT_CYCLES;
      iss_q.push_back(it);
      ok = (ke < TIMEOUT_CYCLES) && (ke + me <= TIMEOUT_CYCLES);
    end
    if (expect_out) begin
      if (ok) begin
        rw.addr = rd; rw.data = res;
        rf_q.push_back(rw);
      end
      if (xd) begin
        rp.rd = rd; rp.data = ok ? {32'd0, res} : 64'd0; rp.err = !ok;
        resp_q.push_back(rp);
      end
    end
    pu = legal ? int'(f7) - 1 : 0;
    pk = legal ? k : 0;
    pm = m; pres = res; icnt = 0; wcnt = 0;
    cmd_inst  = {f7, 5'($urandom), 5'($urandom), xd, 2'($urandom), rd, 2'b11};
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_inst  = (INST_WIDTH-5)'($urandom);
  endtask

  // Operation units: selected unit acks on its k-th strobe cycle and returns
  // its result on the m-th cycle it is allowed to; the rest chatter randomly.
  initial begin
    op_busy = '0; op_out_stb = '0; op_result = '0;
    forever begin
      @(posedge clk); #1;
      for (int u = 0; u < NUM_OPS; u++) begin
        op_busy[u]    = 1'($urandom);
        op_out_stb[u] = ($urandom % 4) == 0;
        op_result[u*OP_WIDTH +: OP_WIDTH] = $urandom;
      end
      if (op_in_stb[pu]) begin
        icnt++;
        op_busy[pu] = (icnt == pk);
      end
      if (!op_out_busy[pu]) begin
        wcnt++;
        op_out_stb[pu] = (wcnt == pm);
        if (wcnt == pm) op_result[pu*OP_WIDTH +: OP_WIDTH] = pres;
      end
    end
  end

  initial begin
    resp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (hold_low > 0) begin
        resp_ready = 1'b0;
        hold_low--;
      end else begin
        resp_ready = 1'($urandom);
      end
    end
  end

  // Monitor: issue strobes, operands and result-side busy.
  iss_t cur;
  bit   iss_open = 0, wait_open = 0;
  int   iss_cnt = 0;
  always @(negedge clk) begin
    logic [NUM_OPS-1:0] exp_ob;
    if (!rst) begin
      iss_open = 0; wait_open = 0;
    end else begin
      if (op_in_stb != '0) begin
        if (!iss_open) begin
          iss_open = 1; iss_cnt = 1;
          if (iss_q.size() == 0) begin
            chk("unexpected_strobe", 64'(op_in_stb), 64'd0);
          end else begin
            cur = iss_q.pop_front();
            chk("op_in_stb", 64'(op_in_stb), 64'(cur.onehot));
            chk("op_a_b", {op_a, op_b}, {cur.a, cur.b});
            chk("op_c_d", {op_c, op_d}, {cur.c, cur.d});
          end
        end else begin
          iss_cnt++;
        end
      end else if (iss_open) begin
        iss_open = 0;
        chk("issue_cycles", 64'(iss_cnt), 64'(cur.cycles));
      end
      if (op_out_busy != '1) begin
        if (!wait_open) begin
          wait_open = 1;
          exp_ob = ~cur.onehot;
          chk("op_out_busy", 64'(op_out_busy), 64'(exp_ob));
        end
      end else begin
        wait_open = 0;
      end
    end
  end

  // Monitor: register-file writes.
  always @(negedge clk) begin
    rf_t e;
    if (rf_we) begin
      if (rf_q.size() == 0) begin
        chk("unexpected_rf_we", 64'(rf_we), 64'd0);
      end else begin
        e = rf_q.pop_front();
        chk("rf_waddr", 64'(rf_waddr), 64'(e.addr));
        chk("rf_wdata", 64'(rf_wdata), 64'(e.data));
      end
    end
  end

  // Monitor: responses, including field stability while stalled.
  bit          resp_open = 0;
  logic [63:0] held_data;
  logic [5:0]  held_rd_err;
  always @(negedge clk) begin
    resp_t e;
    if (!rst) begin
      resp_open = 0;
    end else if (resp_valid) begin
      if (!resp_open) begin
        resp_open   = 1;
        held_data   = resp_data;
        held_rd_err = {resp_rd, resp_err};
        if (resp_q.size() == 0) begin
          chk("unexpected_resp", 64'(resp_valid), 64'd0);
        end else begin
          e = resp_q.pop_front();
          chk("resp_rd", 64'(resp_rd), 64'(e.rd));
          chk("resp_data", resp_data, e.data);
          chk("resp_err", 64'(resp_err), 64'(e.err));
          chk("cmd_ready_in_resp", 64'(cmd_ready), 64'd0);
          chk("busy_in_resp", 64'(busy), 64'd1);
        end
      end else begin
        chk("resp_data_stable", resp_data, held_data);
        chk("resp_rd_err_stable", 64'({resp_rd, resp_err}), 64'(held_rd_err));
      end
      if (resp_ready) resp_open = 0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1);
  end

  initial begin
    logic [NUM_OPS-1:0] exp_ob;
    int n;
    cmd_valid = 1'b0; cmd_inst = '0; cmd_rs1 = '0; cmd_rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;

    send(7'd2, 64'h0000_0001_0000_0002, 64'h0000_0003_0000_0004, 1'b1, 5'd7, 1, 3, 32'hDEAD_BEEF, 1);
    send(7'd0, {2{$urandom}}, {2{$urandom}}, 1'b1, 5'd4, 1, 1, 32'h1111_1111, 1);
    send(7'(NUM_OPS + 1), {2{$urandom}}, {2{$urandom}}, 1'b1, 5'd5, 1, 1, 32'h2222_2222, 1);
    send(7'd0, {2{$urandom}}, {2{$urandom}}, 1'b0, 5'd6, 1, 1, 32'h3333_3333, 1);
    send(7'd127, {2{$urandom}}, {2{$urandom}}, 1'b0, 5'd8, 1, 1, 32'h4444_4444, 1);
    send(7'd1, {2{$urandom}}, {2{$urandom}}, 1'b1, 5'd10, 0, 1, 32'h5555_5555, 1);
    send(7'd4, {2{$urandom}}, {2{$urandom}}, 1'b1, 5'd11, 2, 0, 32'h6666_6666, 1);
    send(7'd5, {2{$urandom}}, {2{$urandom}}, 1'b1, 5'd12, 3, 5, 32'h7777_7777, 1);
    send(7'd3, {2{$urandom}}, {2{$urandom}}, 1'b1, 5'd13, 3, 6, 32'h8888_8888, 1);
    hold_low = 16;
    send(7'd1, {2{$urandom}}, {2{$urandom}}, 1'b1, 5'd14, 1, 1, 32'hCAFE_F00D, 1);

    // reset while a unit result is outstanding
    send(7'd3, {2{$urandom}}, {2{$urandom}}, 1'b1, 5'd9, 1, 0, 32'h9999_9999, 0);
    n = 0;
    while (op_out_busy == '1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    exp_ob = ~(NUM_OPS'(1) << 2);
    chk("reached_wait", 64'(op_out_busy), 64'(exp_ob));
    #2 rst = 1'b0;
    #1 check_reset_values("async_reset");
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    send(7'd5, 64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 5'd31, 2, 2, 32'h0BAD_CAFE, 1);

    for (int i = 0; i < 150; i++) begin
      logic [6:0] f7;
      int k, m;
      f7 = (($urandom % 10) == 0) ? 7'($urandom) : 7'($urandom % 8);
      k  = (($urandom % 8) == 0) ? 0 : 1 + int'($urandom % 9);
      m  = (($urandom % 8) == 0) ? 0 : 1 + int'($urandom % 9);
      send(f7, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 5'($urandom), k, m, $urandom, 1);
    end

    wait_idle();
    repeat (4) @(posedge clk);
    chk("rf_queue_drained", 64'(rf_q.size()), 64'd0);
    chk("resp_queue_drained", 64'(resp_q.size()), 64'd0);
    chk("issue_queue_drained", 64'(iss_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rocc_op_dispatch.md
Name: rocc_op_dispatch

Overview:
- Parametrised successor to the single-command RoCC accelerator front end.
- Accepts one RoCC command, decodes funct7 to one of NUM_OPS operation units, and drives that unit over the STB/BUSY handshake.
- Collects the unit's result, writes it to the accelerator register file, and, when xd=1, returns a response to the core.
- Adds behaviour the previous generation lacked: illegal-funct7 detection, a per-command watchdog timeout, an error-flagged response channel, and a vectorised unit interface.

Parameters:
- INST_WIDTH, 32, instruction width; bits [INST_WIDTH-1:5] are presented.
- DATA_WIDTH, 64, rs1/rs2/response width; must equal 2*OP_WIDTH.
- OP_WIDTH, 32, operand/result width of each operation unit.
- NUM_OPS, 5, number of operation units (1..127).
- TIMEOUT_CYCLES, 1024, max cycles spent in ISSUE+WAIT before abort; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command ready.
- cmd_inst  in  INST_WIDTH-5  inst[31:5] = {funct7, rs2, rs1, xd, xs1, xs2, rd[4:0], opcode[1:0]}.
- cmd_rs1  in  DATA_WIDTH  source operand 1.
- cmd_rs2  in  DATA_WIDTH  source operand 2.
- op_a, op_b, op_c, op_d  out  OP_WIDTH each  operands broadcast to all units.
- op_in_stb  out  NUM_OPS  per-unit input strobe.
- op_busy  in  NUM_OPS  per-unit input acknowledge (unit busy = inputs captured).
- op_out_stb  in  NUM_OPS  per-unit result strobe.
- op_result  in  NUM_OPS*OP_WIDTH  unit i result at [i*OP_WIDTH +: OP_WIDTH].
- op_out_busy  out  NUM_OPS  per-unit result-side busy; low means the result can be taken.
- rf_we  out  1  register-file write enable.
- rf_waddr  out  5  register-file write address.
- rf_wdata  out  OP_WIDTH  register-file write data.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response ready.
- resp_rd  out  5  destination register.
- resp_data  out  DATA_WIDTH  result, zero-extended.
- resp_err  out  1  response carries an illegal-funct7 or timeout error.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, cmd_ready=1.
  - op_in_stb=0, op_out_busy=all 1, rf_we=0, resp_valid=0, resp_err=0, busy=0.
  - Operand/data registers=0; watchdog counter=0.
  - Reset mid-operation aborts silently: no RF write, no response; strobes drop immediately.
- All outputs are registered.
- IDLE:
  - cmd_ready=1. On cmd_valid&&cmd_ready: latch the decoded fields, rs1, rs2; set cmd_ready=0.
  - Selection: sel=funct7-1 if 1<=funct7<=NUM_OPS.
  - Legal funct7: go ISSUE.
  - Illegal funct7: go ERR.
- Operand mapping (latched at acceptance): op_a=rs1[63:32], op_b=rs1[31:0], op_c=rs2[63:32], op_d=rs2[31:0]. Held stable until the next accept.
- ISSUE:
  - op_in_stb[sel]=1 from the first ISSUE cycle; all other bits stay 0.
  - On a cycle where op_in_stb[sel]&&op_busy[sel]: clear the strobe next edge, go WAIT.
  - op_busy of non-selected units is ignored.
- WAIT:
  - op_out_busy[sel]=0; all other bits stay 1.
  - On op_out_stb[sel]&&!op_out_busy[sel]: capture op_result slice into result, set op_out_busy[sel]=1, go WB.
  - op_out_stb of other units is ignored.
- Watchdog:
  - Loaded with TIMEOUT_CYCLES on accept; decrements each ISSUE/WAIT cycle.
  - Reaching 0 (TIMEOUT_CYCLES!=0): drop op_in_stb, set op_out_busy=all 1, go ERR.
  - If the result handshake and expiry occur in the same cycle, the result wins.
- WB (1 cycle): rf_we=1, rf_waddr=rd, rf_wdata=result. Next state is RESP if xd, else IDLE.
- ERR (1 cycle):
  - No RF write; result=0. Next state is RESP with resp_err=1 if xd, else IDLE.
  - The error is reported only via resp_err; xd=0 errors are dropped.
- RESP:
  - resp_valid=1 with resp_rd=rd, resp_data={{OP_WIDTH{0}},result}, resp_err.
  - All response fields are held stable until resp_ready. Then resp_valid=0, resp_err=0, go IDLE.
  - resp_ready asserted while resp_valid=0 has no effect.
- Throughput: one command in flight. cmd_ready returns to 1 on the edge that enters IDLE.
- Minimum latency, accept to rf_we, with unit ack and result at first opportunity: accept edge T; op_in_stb visible at T+1; ack at T+1 → WAIT at T+2; result at T+2 → WB at T+3; rf_we high during T+3.
- cmd_valid while cmd_ready=0 is ignored; the command is neither latched nor lost-acknowledged.

Test Plan:
- funct7=2, rs1=0x0000_0001_0000_0002, rs2=0x0000_0003_0000_0004, xd=1, rd=7; unit1 acks in 1 cycle and returns 0xDEAD_BEEF after 3 cycles → only op_in_stb[1] pulses; op_a..op_d=1,2,3,4; rf_we one cycle with waddr=7, wdata=0xDEADBEEF; resp_data=0x0000_0000_DEAD_BEEF, resp_err=0.
- funct7=0 then funct7=NUM_OPS+1, xd=1 → no op_in_stb; no rf_we; resp_valid with resp_err=1, resp_data=0. With xd=0 → straight back to IDLE.
- TIMEOUT_CYCLES=8, funct7=1, unit never acks → exactly 8 ISSUE cycles, then op_in_stb drops, resp_err=1. Repeat with ack but no op_out_stb → timeout from WAIT.
- xd=1, resp_ready held low 10 cycles → resp_valid and fields stable for 10 cycles; cmd_ready=0 throughout; cmd_valid pulses ignored.
- Result strobe on the same cycle as watchdog expiry → normal WB and resp_err=0. Stray op_out_stb from a non-selected unit → ignored.
- Assert rst low during WAIT → all outputs take reset values asynchronously; the next command completes normally.
